emblem_sequencer: RTL and testbench
===================================

# emblem_sequencer

Frame-synchronous controller for the shield emblem overlay. Sequences a show cycle: slide in from below, hold, blink, slide out. It does this by translating the raster coordinates fed to the emblem generator and gating its `active` input. It also composites the generator's colour over the background video, honouring the transparent key. It sits between the VGA timing block / background generator and the emblem generator, feeding the output pixel register.

## Interface
- `SLIDE_STEP`, 8: vertical offset change per frame during slides (pixels).
- `OFFSET_MAX`, 480: fully off-screen offset; reset and IDLE value.
- `HOLD_FRAMES`, 120: frames spent in HOLD.
- `BLINK_HALF`, 15: frames per blink half-period.
- `BLINK_TOGGLES`, 6: visibility toggles in BLINK (even, so the block ends visible).

- `clk`, in, 1: pixel clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `frame_start`, in, 1: one-cycle pulse at the first vertical-blank line.
- `start`, in, 1: request a show cycle; level or pulse.
- `stop`, in, 1: abort; forces SLIDE_OUT.
- `x`, in, 10: raster column.
- `y`, in, 10: raster row.
- `active`, in, 1: display-area flag from timing.
- `bg_rgb`, in, 6: background pixel, same cycle as `x`/`y`.
- `emb_rgb`, in, 6: emblem generator output for `emb_x`/`emb_y`.
- `emb_x`, out, 10: column to emblem generator.
- `emb_y`, out, 10: row to emblem generator.
- `emb_active`, out, 1: active to emblem generator.
- `rgb_out`, out, 6: composited pixel, registered.
- `busy`, out, 1: high in every state except IDLE.
- `state`, out, 3: current state encoding, for debug.

## Operation
- States: IDLE=0, SLIDE_IN=1, HOLD=2, BLINK=3, SLIDE_OUT=4. All state, offset, timer and visibility updates happen only on cycles with `frame_start`=1, which guarantees no mid-frame tearing.
- **IDLE**: offset=OFFSET_MAX, visible=0. On `frame_start` with `start`=1 and `stop`=0, go to SLIDE_IN and set visible=1. `start` is ignored in every other state.
- **SLIDE_IN**: offset ← max(offset−SLIDE_STEP, 0). The frame on which the new offset becomes 0 loads timer=HOLD_FRAMES−1 and moves to HOLD.
- **HOLD**: timer decrements per frame. At timer=0, go to BLINK with timer=BLINK_HALF−1 and toggles=0.
- **BLINK**: at timer=0: visible toggles, toggles increments and the timer reloads. After BLINK_TOGGLES toggles, go to SLIDE_OUT.
- **SLIDE_OUT**: visible=1, offset ← min(offset+SLIDE_STEP, OFFSET_MAX). On reaching OFFSET_MAX, go to IDLE.
- **stop**: `stop`=1 on `frame_start` in SLIDE_IN, HOLD or BLINK gives SLIDE_OUT next, with visible=1 and offset continuing from its current value. In IDLE or SLIDE_OUT, `stop` has no effect. `stop` beats `start` when both are high.
- **Coordinate translation**, combinational:
  - `emb_x`=`x`.
  - `emb_y`=`y`−offset, 10-bit wrap.
  - `emb_active`=`active` ∧ visible ∧ (`y` ≥ offset) ∧ `busy`.
- **Compositing**, registered: `rgb_out` ← (`emb_active` ∧ `emb_rgb`≠TRANSPARENT(6'b100001)) ? `emb_rgb` : (`active` ? `bg_rgb` : 0).
- Offset arithmetic is 10-bit unsigned and saturating at both ends. Do not rely on OFFSET_MAX being a multiple of SLIDE_STEP.

## Timing
- Reset values: state=IDLE, offset=OFFSET_MAX, timer=0, toggles=0, visible=0, `rgb_out`=0, `busy`=0. Combinational outputs follow from these values, so `emb_active`=0.
- `emb_x`/`emb_y`/`emb_active` have zero latency from `x`/`y`. `rgb_out` has 1-cycle latency from `x`/`y`/`bg_rgb`. The parent delays sync signals by 1 cycle to match.
- State changes are visible from the cycle after the `frame_start` cycle.
- Frame counts with default parameters:
  - SLIDE_IN: 60 frames from 480.
  - HOLD: 120 frames.
  - BLINK: 6×15=90 frames.
  - SLIDE_OUT: 60 frames.
- Reset asserted mid-cycle returns the block to IDLE immediately (asynchronously). The first show after release needs a fresh `start`.

## Structure
- Shared package `emblem_pkg`:
  - state enum.
  - COLOR_TRANSPARENT=6'b100001.
  - COLOR_BLACK.
  - screen height 480.
- One natural sub-module, `frame_timer`: a loadable 8-bit down-counter with zero flag, advanced by `frame_start`. It is reused for HOLD and blink half-periods.
- The emblem generator is instantiated by the parent, not inside this block.

## Test plan
- **Reset idle**: reset, run 3 frames → `busy`=0, `emb_active`=0 and `rgb_out`=`bg_rgb` delayed 1 cycle. With `active`=0, `rgb_out`=0.
- **Full cycle**: pulse `start` before frame 0 → SLIDE_IN, offset 472 at frame 1 and 0 at frame 60. Then HOLD for 120 frames and BLINK for 90 frames, ending visible. Then SLIDE_OUT reaches 480 after 60 frames, then IDLE.
- **Translation**: offset=200 and `y`=199 → `emb_active`=0. With `y`=300 → `emb_y`=100 and `emb_active`=`active`.
- **Compositing**:
  - `emb_rgb`=6'b100001 → `rgb_out`=`bg_rgb`.
  - `emb_rgb`=6'b110110 → `rgb_out`=6'b110110 next cycle.
- **Stop**: `stop` in HOLD → SLIDE_OUT next frame, offset 8, 16, … up to 480, then IDLE. `start`+`stop` together in IDLE → remains IDLE.
- **Saturation and reset**: SLIDE_STEP=7 → offset clamps to 0 and to 480 exactly. Reset in BLINK → IDLE, offset 480, `rgb_out`=0 immediately.

Source files
------------

// File: rtl/emblem_pkg.sv
// rtl/emblem_pkg.sv - shared types, colour keys and saturating offset helpers for the emblem sequencer
package emblem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SLIDE_IN  = 3'd1,
        ST_HOLD      = 3'd2,
        ST_BLINK     = 3'd3,
        ST_SLIDE_OUT = 3'd4
    } emb_state_t;

    localparam logic [5:0] COLOR_TRANSPARENT = 6'b100001;
    localparam logic [5:0] COLOR_BLACK       = 6'b000000;
    localparam int         SCREEN_HEIGHT     = 480;

    // Subtract, clamping at zero instead of wrapping.
    function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : 10'd0;
    endfunction

    // Add, clamping at lim; computed in 11 bits so the sum itself cannot wrap.
    function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [9:0] b,
                                           input logic [9:0] lim);
        logic [10:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= {1'b0, lim}) ? lim : sum[9:0];
    endfunction

endpackage

// File: rtl/emblem_sequencer_if.sv
// rtl/emblem_sequencer_if.sv - pixel-path bundle between raster source, emblem generator and sequencer
interface emblem_sequencer_if;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic [5:0] bg_rgb;
    logic [5:0] emb_rgb;
    logic [9:0] emb_x;
    logic [9:0] emb_y;
    logic       emb_active;
    logic [5:0] rgb_out;

    // Raster/generator side: supplies coordinates and colours, consumes the composite.
    modport master (
        output x, y, active, bg_rgb, emb_rgb,
        input  emb_x, emb_y, emb_active, rgb_out
    );

    // Sequencer side.
    modport slave (
        input  x, y, active, bg_rgb, emb_rgb,
        output emb_x, emb_y, emb_active, rgb_out
    );
endinterface

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - loadable 8-bit frame down-counter with zero flag
module frame_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] count;

    // Load wins over counting; the counter parks at zero rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (advance && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/emblem_sequencer.sv
// rtl/emblem_sequencer.sv - frame-synchronous slide/hold/blink sequencer and emblem compositor
module emblem_sequencer
    import emblem_pkg::*;
#(
    parameter int SLIDE_STEP    = 8,
    parameter int OFFSET_MAX    = SCREEN_HEIGHT,
    parameter int HOLD_FRAMES   = 120,
    parameter int BLINK_HALF    = 15,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                start,
    input  logic                stop,
    emblem_sequencer_if.slave   vif,
    output logic                busy,
    output logic [2:0]          state
);

    localparam logic [9:0] STEP_W   = 10'(SLIDE_STEP);
    localparam logic [9:0] MAX_W    = 10'(OFFSET_MAX);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] BLINK_LD = 8'(BLINK_HALF - 1);
    localparam logic [3:0] TOG_W    = 4'(BLINK_TOGGLES);

    emb_state_t st;
    logic [9:0] offset;
    logic       visible;
    logic [3:0] toggles;
    logic [5:0] rgb_q;

    logic [9:0] off_dn;
    logic [9:0] off_up;
    logic [3:0] toggles_nx;
    logic       tmr_load;
    logic [7:0] tmr_val;
    logic       tmr_zero;
    logic       emb_act;

    assign off_dn     = sat_sub(offset, STEP_W);
    assign off_up     = sat_add(offset, STEP_W, MAX_W);
    assign toggles_nx = toggles + 4'd1;

    // Decide when the shared timer is reloaded: entering HOLD and every blink half-period.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = 8'd0;
        if (frame_start && !stop) begin
            case (st)
                ST_SLIDE_IN: begin
                    if (off_dn == 10'd0) begin
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LD;
                    end
                end
                ST_HOLD, ST_BLINK: begin
                    if (tmr_zero) begin
                        tmr_load = 1'b1;
                        tmr_val  = BLINK_LD;
                    end
                end
                default: ;
            endcase
        end
    end

    frame_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .advance  (frame_start),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Show-cycle FSM; everything moves only on frame_start so a frame never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= ST_IDLE;
            offset  <= MAX_W;
            visible <= 1'b0;
            toggles <= 4'd0;
            busy    <= 1'b0;
        end else if (frame_start) begin
            case (st)
                ST_IDLE: begin
                    offset <= MAX_W;
                    if (start && !stop) begin
                        st      <= ST_SLIDE_IN;
                        visible <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        visible <= 1'b0;
                    end
                end
                ST_SLIDE_IN: begin
                    if (stop) begin
                        st      <= ST_SLIDE_OUT;
                        visible <= 1'b1;
                    end else begin
                        offset <= off_dn;
                        if (off_dn == 10'd0) begin
                            st <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (stop) begin
                        st      <= ST_SLIDE_OUT;
                        visible <= 1'b1;
                    end else if (tmr_zero) begin
                        st      <= ST_BLINK;
                        toggles <= 4'd0;
                    end
                end
                ST_BLINK: begin
                    if (stop) begin
                        st      <= ST_SLIDE_OUT;
                        visible <= 1'b1;
                    end else if (tmr_zero) begin
                        toggles <= toggles_nx;
                        if (toggles_nx == TOG_W) begin
                            st      <= ST_SLIDE_OUT;
                            visible <= 1'b1;
                        end else begin
                            visible <= ~visible;
                        end
                    end
                end
                ST_SLIDE_OUT: begin
                    offset <= off_up;
                    if (off_up == MAX_W) begin
                        st      <= ST_IDLE;
                        visible <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        visible <= 1'b1;
                    end
                end
                default: begin
                    st      <= ST_IDLE;
                    offset  <= MAX_W;
                    visible <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign state = st;

    // Coordinate translation into emblem space, zero latency.
    assign emb_act        = vif.active & visible & (vif.y >= offset) & busy;
    assign vif.emb_x      = vif.x;
    assign vif.emb_y      = vif.y - offset;
    assign vif.emb_active = emb_act;

    // Composite emblem over background, keying out the transparent colour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= COLOR_BLACK;
        end else if (emb_act && (vif.emb_rgb != COLOR_TRANSPARENT)) begin
            rgb_q <= vif.emb_rgb;
        end else if (vif.active) begin
            rgb_q <= vif.bg_rgb;
        end else begin
            rgb_q <= COLOR_BLACK;
        end
    end

    assign vif.rgb_out = rgb_q;

endmodule

// File: tb/tb_emblem_sequencer.sv
// tb/tb_emblem_sequencer.sv - directed self-checking bench for emblem_sequencer
module tb_emblem_sequencer;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic       start;
    logic       start2;
    logic       stop;
    logic       busy;
    logic       busy2;
    logic [2:0] state;
    logic [2:0] state2;

    int n_checks = 0;
    int n_fail   = 0;
    int off;

    emblem_sequencer_if vif ();
    emblem_sequencer_if vif2 ();

    emblem_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .start       (start),
        .stop        (stop),
        .vif         (vif),
        .busy        (busy),
        .state       (state)
    );

    emblem_sequencer #(.SLIDE_STEP(7)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .start       (start2),
        .stop        (stop),
        .vif         (vif2),
        .busy        (busy2),
        .state       (state2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame = a frame_start cycle followed by one quiet cycle; ends 1 time unit after an edge.
    task automatic do_frames(input int n);
        repeat (n) begin
            frame_start = 1'b1;
            @(posedge clk);
            #1 frame_start = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // Recover the vertical offset from emb_y with y=0 (emb_y = -offset mod 1024).
    task automatic read_off(output int o);
        vif.y = 10'd0;
        #1 o = (1024 - int'(vif.emb_y)) % 1024;
    endtask

    task automatic read_off2(output int o);
        vif2.y = 10'd0;
        #1 o = (1024 - int'(vif2.emb_y)) % 1024;
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; start = 1'b0; start2 = 1'b0; stop = 1'b0;
        vif.x = '0; vif.y = '0; vif.active = 1'b0; vif.bg_rgb = '0; vif.emb_rgb = '0;
        vif2.x = '0; vif2.y = '0; vif2.active = 1'b0; vif2.bg_rgb = '0; vif2.emb_rgb = '0;

        // Reset and idle behaviour
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", int'(state), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rgb", int'(vif.rgb_out), 0);
        rst = 1'b0;
        do_frames(3);
        check("idle_busy", int'(busy), 0);
        check("idle_state", int'(state), 0);
        vif.active = 1'b1; vif.y = 10'd300; vif.x = 10'd123;
        vif.bg_rgb = 6'h15; vif.emb_rgb = 6'h36;
        #1;
        check("idle_emb_active", int'(vif.emb_active), 0);
        check("emb_x", int'(vif.emb_x), 123);
        @(posedge clk); #1;
        check("idle_rgb_bg", int'(vif.rgb_out), 21);
        vif.active = 1'b0;
        @(posedge clk); #1;
        check("idle_rgb_blank", int'(vif.rgb_out), 0);

        // Full show cycle
        start = 1'b1;
        do_frames(1);
        start = 1'b0;
        check("in_state", int'(state), 1);
        check("in_busy", int'(busy), 1);
        read_off(off); check("in_off0", off, 480);
        do_frames(1);
        read_off(off); check("in_off1", off, 472);
        do_frames(34);
        read_off(off); check("in_off35", off, 200);

        // Translation at offset 200
        vif.active = 1'b1; vif.y = 10'd199;
        #1 check("tr_above", int'(vif.emb_active), 0);
        vif.y = 10'd300;
        #1 check("tr_emb_y", int'(vif.emb_y), 100);
        check("tr_active", int'(vif.emb_active), 1);
        vif.active = 1'b0;
        #1 check("tr_inactive", int'(vif.emb_active), 0);

        // Compositing
        vif.active = 1'b1; vif.emb_rgb = 6'b100001; vif.bg_rgb = 6'h0A;
        @(posedge clk); #1;
        check("cmp_transparent", int'(vif.rgb_out), 10);
        vif.emb_rgb = 6'b110110;
        @(posedge clk); #1;
        check("cmp_emblem", int'(vif.rgb_out), 54);

        do_frames(24);
        read_off(off); check("in_off59", off, 8);
        check("in_state59", int'(state), 1);
        do_frames(1);
        read_off(off); check("in_off60", off, 0);
        check("hold_enter", int'(state), 2);

        do_frames(119);
        check("hold_119", int'(state), 2);
        do_frames(1);
        check("blink_enter", int'(state), 3);

        vif.y = 10'd300; vif.active = 1'b1;
        do_frames(14);
        check("blink_vis14", int'(vif.emb_active), 1);
        do_frames(1);
        check("blink_vis15", int'(vif.emb_active), 0);
        do_frames(74);
        check("blink_89", int'(state), 3);
        do_frames(1);
        check("out_enter", int'(state), 4);
        check("out_visible", int'(vif.emb_active), 1);

        do_frames(1);
        read_off(off); check("out_off1", off, 8);
        do_frames(58);
        read_off(off); check("out_off59", off, 472);
        check("out_state59", int'(state), 4);
        do_frames(1);
        read_off(off); check("out_off60", off, 480);
        check("done_state", int'(state), 0);
        check("done_busy", int'(busy), 0);

        // Stop during HOLD
        start = 1'b1;
        do_frames(1);
        start = 1'b0;
        do_frames(65);
        check("stop_pre", int'(state), 2);
        stop = 1'b1;
        do_frames(1);
        stop = 1'b0;
        check("stop_state", int'(state), 4);
        read_off(off); check("stop_off0", off, 0);
        do_frames(1);
        read_off(off); check("stop_off1", off, 8);
        do_frames(1);
        read_off(off); check("stop_off2", off, 16);
        do_frames(57);
        read_off(off); check("stop_off59", off, 472);
        check("stop_state59", int'(state), 4);
        do_frames(1);
        read_off(off); check("stop_off60", off, 480);
        check("stop_idle", int'(state), 0);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        do_frames(1);
        start = 1'b0; stop = 1'b0;
        check("startstop_state", int'(state), 0);
        check("startstop_busy", int'(busy), 0);

        // Saturation with a step that does not divide 480
        start2 = 1'b1;
        do_frames(1);
        start2 = 1'b0;
        check("s7_state", int'(state2), 1);
        do_frames(68);
        read_off2(off); check("s7_off68", off, 4);
        check("s7_state68", int'(state2), 1);
        do_frames(1);
        read_off2(off); check("s7_off69", off, 0);
        check("s7_hold", int'(state2), 2);
        stop = 1'b1;
        do_frames(1);
        stop = 1'b0;
        check("s7_out", int'(state2), 4);
        check("s7_dut1_idle", int'(state), 0);
        do_frames(68);
        read_off2(off); check("s7_up68", off, 476);
        check("s7_up_state", int'(state2), 4);
        do_frames(1);
        read_off2(off); check("s7_up69", off, 480);
        check("s7_idle", int'(state2), 0);

        // Asynchronous reset during BLINK
        start = 1'b1;
        do_frames(1);
        start = 1'b0;
        do_frames(183);
        check("rb_blink", int'(state), 3);
        vif.active = 1'b1; vif.y = 10'd300; vif.bg_rgb = 6'h2A; vif.emb_rgb = 6'h33;
        @(posedge clk); #1;
        check("rb_rgb_pre", int'(vif.rgb_out), 51);
        #3 rst = 1'b1;
        #1;
        check("rb_state", int'(state), 0);
        check("rb_busy", int'(busy), 0);
        check("rb_rgb", int'(vif.rgb_out), 0);
        read_off(off); check("rb_off", off, 480);
        @(posedge clk);
        #1 rst = 1'b0;
        do_frames(2);
        check("rb_no_restart", int'(state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
